// File: rtl/imem_fetch_unit.sv
// Word-organised instruction store with self-clearing init, sequential load port,
// registered fetch with fault flags. Optional parity storage: IMEM_PARITY_EN.
module imem_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  startin,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  output logic                  misaligned,
  output logic                  out_of_range,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_full,
  output logic                  busy,
  input  logic                  parity_inject,
  output logic                  parity_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {INIT, READY} state_t;

  state_t                  state_reg;
  logic [AW-1:0]           clr_ptr_reg;
  logic [AW:0]             load_ptr_reg;
  logic [DATA_WIDTH-1:0]   instruction_reg;
  logic                    instr_valid_reg;
  logic                    misaligned_reg;
  logic                    out_of_range_reg;
  logic                    load_full_reg;
  logic                    busy_reg;
  logic                    parity_err_reg;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    mem_we;
  logic [AW-1:0]           mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic [AW-1:0]           rd_idx;
  logic                    fetch_mis;
  logic                    fetch_oor;
  logic                    fetch_fault;
  logic                    load_accept;
  logic                    par_mismatch;

  assign rd_idx      = address[AW+1:2];
  assign fetch_mis   = |address[1:0];
  assign fetch_oor   = (address >> (AW + 2)) != '0;
  assign fetch_fault = fetch_mis | fetch_oor;

  // The top bit of load_ptr_reg is set exactly when all DEPTH words are loaded.
  assign load_accept = load_en & ~load_ptr_reg[AW];

  // One write port shared by the clear sequence and the load port.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = NOP_WORD;
    if (!startin) begin
      if (state_reg == INIT) begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_reg;
      end else if (load_accept) begin
        mem_we    = 1'b1;
        mem_waddr = load_ptr_reg[AW-1:0];
        mem_wdata = load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];
  logic mem_wpar;

  always_comb begin
    mem_wpar = ^NOP_WORD;
    if (state_reg == READY) begin
      mem_wpar = (^load_data) ^ parity_inject;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_mem[mem_waddr] <= mem_wpar;
    end
  end

  assign par_mismatch = (^mem[rd_idx]) ^ par_mem[rd_idx];
`else
  logic unused_parity_inject;
  assign unused_parity_inject = parity_inject;
  assign par_mismatch         = 1'b0;
`endif

  // The fetch result register samples the array before this cycle's write lands,
  // so a same-cycle fetch of the word being loaded sees the old contents.
  always_ff @(posedge clk) begin
    if (startin) begin
      state_reg        <= INIT;
      clr_ptr_reg      <= '0;
      load_ptr_reg     <= '0;
      instruction_reg  <= NOP_WORD;
      instr_valid_reg  <= 1'b0;
      misaligned_reg   <= 1'b0;
      out_of_range_reg <= 1'b0;
      load_full_reg    <= 1'b0;
      busy_reg         <= 1'b1;
      parity_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          instr_valid_reg  <= 1'b0;
          misaligned_reg   <= 1'b0;
          out_of_range_reg <= 1'b0;
          parity_err_reg   <= 1'b0;
          clr_ptr_reg      <= clr_ptr_reg + 1'b1;
          if (clr_ptr_reg == AW'(DEPTH - 1)) begin
            state_reg <= READY;
            busy_reg  <= 1'b0;
          end
        end
        READY: begin
          instr_valid_reg <= fetch_req;
          if (fetch_req) begin
            misaligned_reg   <= fetch_mis;
            out_of_range_reg <= fetch_oor;
            instruction_reg  <= fetch_fault ? NOP_WORD : mem[rd_idx];
            parity_err_reg   <= ~fetch_fault & par_mismatch;
          end else begin
            misaligned_reg   <= 1'b0;
            out_of_range_reg <= 1'b0;
            parity_err_reg   <= 1'b0;
          end
          if (load_accept) begin
            load_ptr_reg  <= load_ptr_reg + 1'b1;
            load_full_reg <= (load_ptr_reg + 1'b1) == (AW + 1)'(DEPTH);
          end
        end
        default: begin
          state_reg <= INIT;
        end
      endcase
    end
  end

  assign instruction  = instruction_reg;
  assign instr_valid  = instr_valid_reg;
  assign misaligned   = misaligned_reg;
  assign out_of_range = out_of_range_reg;
  assign load_full    = load_full_reg;
  assign busy         = busy_reg;
  assign parity_err   = parity_err_reg;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit (DEPTH=64): init, load, fetch, faults, restart, parity.
module tb_imem_fetch_unit;

  logic        clk = 1'b0;
  logic        startin = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        misaligned;
  logic        out_of_range;
  logic        load_en = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_full;
  logic        busy;
  logic        parity_inject = 1'b0;
  logic        parity_err;

  int compared = 0;
  int mismatched = 0;

  imem_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .NOP_WORD(32'h0)) dut (
    .clk(clk), .startin(startin), .fetch_req(fetch_req), .address(address),
    .instruction(instruction), .instr_valid(instr_valid), .misaligned(misaligned),
    .out_of_range(out_of_range), .load_en(load_en), .load_data(load_data),
    .load_full(load_full), .busy(busy), .parity_inject(parity_inject),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts sampled cycles with busy high, starting at the current sample.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  task automatic do_init();
    int cnt;
    startin = 1'b1;
    tick();
    startin = 1'b0;
    count_busy(cnt);
  endtask

  task automatic load_word(input logic [31:0] w);
    load_en = 1'b1;
    load_data = w;
    tick();
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    startin = 1'b1;
    tick();
    tick();
    compared++;
    if (busy !== 1'b1 || instr_valid !== 1'b0 || load_full !== 1'b0 || instruction !== 32'h0
        || misaligned !== 1'b0 || out_of_range !== 1'b0 || parity_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: busy=%b valid=%b full=%b instr=%h mis=%b oor=%b perr=%b, want 1 0 0 00000000 0 0 0",
               busy, instr_valid, load_full, instruction, misaligned, out_of_range, parity_err);
    end
    startin = 1'b0;
    count_busy(cnt);
    compared++;
    if (cnt !== 64) begin
      mismatched++;
      $display("FAIL init_length: busy cycles=%0d, want 64", cnt);
    end
    fetch_req = 1'b1;
    address = 32'h20;
    tick();
    fetch_req = 1'b0;
    compared++;
    if (instr_valid !== 1'b1 || instruction !== 32'h0 || misaligned !== 1'b0 || out_of_range !== 1'b0) begin
      mismatched++;
      $display("FAIL init_fetch: valid=%b instr=%h mis=%b oor=%b, want 1 00000000 0 0",
               instr_valid, instruction, misaligned, out_of_range);
    end
    tick();
    compared++;
    if (instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL valid_pulse: valid=%b, want 0", instr_valid);
    end
    $display("test_reset: busy cycles=%0d", cnt);
  endtask

  task automatic test_load_fetch();
    logic [31:0] prog [3];
    prog[0] = 32'h8C010004;
    prog[1] = 32'h00221820;
    prog[2] = 32'hAC030008;
    for (int i = 0; i < 3; i++) load_word(prog[i]);
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1;
      address = 32'(i * 4);
      tick();
      compared++;
      if (instr_valid !== 1'b1 || instruction !== prog[i] || misaligned !== 1'b0 || out_of_range !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_fetch%0d: valid=%b instr=%h mis=%b oor=%b, want 1 %h 0 0",
                 i, instr_valid, instruction, misaligned, out_of_range, prog[i]);
      end
      $display("test_load_fetch: addr=%h instr=%h", address, instruction);
    end
    fetch_req = 1'b0;
    tick();
    compared++;
    if (instr_valid !== 1'b0 || instruction !== prog[2]) begin
      mismatched++;
      $display("FAIL idle_hold: valid=%b instr=%h, want 0 %h", instr_valid, instruction, prog[2]);
    end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [3];
    logic [1:0]  flags [3];
    addrs[0] = 32'h6;   flags[0] = 2'b10;
    addrs[1] = 32'h100; flags[1] = 2'b01;
    addrs[2] = 32'h102; flags[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1;
      address = addrs[i];
      tick();
      fetch_req = 1'b0;
      compared++;
      if (instr_valid !== 1'b1 || {misaligned, out_of_range} !== flags[i] || instruction !== 32'h0) begin
        mismatched++;
        $display("FAIL fault_%h: valid=%b mis/oor=%b%b instr=%h, want 1 %b 00000000",
                 addrs[i], instr_valid, misaligned, out_of_range, instruction, flags[i]);
      end
      $display("test_faults: addr=%h mis=%b oor=%b", addrs[i], misaligned, out_of_range);
    end
    tick();
  endtask

  task automatic test_full_rbw();
    for (int i = 3; i < 64; i++) begin
      load_word(32'h10000000 + 32'(i));
      compared++;
      if (load_full !== (i == 63)) begin
        mismatched++;
        $display("FAIL load_full_idx%0d: full=%b, want %b", i, load_full, (i == 63));
      end
    end
    load_word(32'hDEADBEEF);
    fetch_req = 1'b1;
    address = 32'h0;
    tick();
    compared++;
    if (instruction !== 32'h8C010004 || load_full !== 1'b1) begin
      mismatched++;
      $display("FAIL no_wrap: instr=%h full=%b, want 8c010004 1", instruction, load_full);
    end
    address = 32'hFC;
    tick();
    fetch_req = 1'b0;
    compared++;
    if (instruction !== 32'h1000003F || out_of_range !== 1'b0) begin
      mismatched++;
      $display("FAIL last_word: instr=%h oor=%b, want 1000003f 0", instruction, out_of_range);
    end
    do_init();
    for (int i = 0; i < 5; i++) load_word(32'hA0000000 + 32'(i));
    load_en = 1'b1;
    load_data = 32'h55AA55AA;
    fetch_req = 1'b1;
    address = 32'h14;
    tick();
    load_en = 1'b0;
    compared++;
    if (instr_valid !== 1'b1 || instruction !== 32'h0) begin
      mismatched++;
      $display("FAIL rbw_old: valid=%b instr=%h, want 1 00000000", instr_valid, instruction);
    end
    tick();
    fetch_req = 1'b0;
    compared++;
    if (instr_valid !== 1'b1 || instruction !== 32'h55AA55AA) begin
      mismatched++;
      $display("FAIL rbw_new: valid=%b instr=%h, want 1 55aa55aa", instr_valid, instruction);
    end
    $display("test_full_rbw: idx5 new=%h", instruction);
    tick();
  endtask

  task automatic test_restart();
    int cnt;
    startin = 1'b1;
    tick();
    startin = 1'b0;
    fetch_req = 1'b1;
    repeat (30) tick();
    compared++;
    if (busy !== 1'b1 || instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL init_ignores_fetch: busy=%b valid=%b, want 1 0", busy, instr_valid);
    end
    fetch_req = 1'b0;
    startin = 1'b1;
    tick();
    startin = 1'b0;
    count_busy(cnt);
    compared++;
    if (cnt !== 64) begin
      mismatched++;
      $display("FAIL restart_length: busy cycles=%0d, want 64", cnt);
    end
    fetch_req = 1'b1;
    address = 32'h0;
    startin = 1'b1;
    tick();
    startin = 1'b0;
    fetch_req = 1'b0;
    compared++;
    if (instr_valid !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_fetch: valid=%b busy=%b, want 0 1", instr_valid, busy);
    end
    count_busy(cnt);
    $display("test_restart: busy cycles=%0d", cnt);
  endtask

  task automatic test_parity();
    logic perr_exp;
`ifdef IMEM_PARITY_EN
    perr_exp = 1'b1;
`else
    perr_exp = 1'b0;
`endif
    parity_inject = 1'b1;
    load_word(32'h12345678);
    parity_inject = 1'b0;
    load_word(32'h0F0F0F0E);
    fetch_req = 1'b1;
    address = 32'h0;
    tick();
    compared++;
    if (parity_err !== perr_exp || instruction !== 32'h12345678 || instr_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL parity_inject: perr=%b instr=%h valid=%b, want %b 12345678 1",
               parity_err, instruction, instr_valid, perr_exp);
    end
    address = 32'h4;
    tick();
    fetch_req = 1'b0;
    compared++;
    if (parity_err !== 1'b0 || instruction !== 32'h0F0F0F0E) begin
      mismatched++;
      $display("FAIL parity_clean: perr=%b instr=%h, want 0 0f0f0f0e", parity_err, instruction);
    end
    tick();
    compared++;
    if (parity_err !== 1'b0) begin
      mismatched++;
      $display("FAIL parity_idle: perr=%b, want 0", parity_err);
    end
    $display("test_parity: expected perr on injected word=%b", perr_exp);
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_faults();
    test_full_rbw();
    test_restart();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
